// File: rtl/mavg_pkg.sv
// Shared types and constants for the boxcar anti-alias filter.
// Rounding in the scaler is enabled by defining MAVG_ROUND_EN.
package mavg_pkg;

    localparam int DATA_W    = 16;
    localparam int TAPS_DEF  = 6;
    localparam int RECIP_DEF = 10923;
    localparam int ACC_W_DEF = DATA_W + $clog2(TAPS_DEF);

    typedef logic signed [DATA_W-1:0]    sample_t;
    typedef logic signed [ACC_W_DEF-1:0] acc_t;

    localparam sample_t SAT_MAX = sample_t'(32767);
    localparam sample_t SAT_MIN = sample_t'(-32768);

    // Q0.16 reciprocal of a window length, rounded to nearest.
    function automatic int recip_for(input int taps);
        return (65536 + taps / 2) / taps;
    endfunction

endpackage

// File: rtl/mavg_delay_line.sv
// Circular delay line holding the last TAPS samples; presents the sample
// about to be overwritten so the accumulator can subtract it.
module mavg_delay_line
    import mavg_pkg::*;
#(
    parameter int TAPS = TAPS_DEF
)(
    input  logic    CLOCK_50,
    input  logic    reset,
    input  sample_t data_in,
    output sample_t oldest
);

    localparam int PTR_W = $clog2(TAPS);

    sample_t          taps_mem [TAPS];
    logic [PTR_W-1:0] wr_ptr;

    assign oldest = taps_mem[wr_ptr];

    // Zeroed entries make warm-up outputs well-defined partial sums.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                taps_mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else begin
            taps_mem[wr_ptr] <= data_in;
            if (wr_ptr == PTR_W'(TAPS - 1)) begin
                wr_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/mavg_antialias.sv
// Boxcar moving-average anti-alias filter ahead of the downsampler.
// Define MAVG_ROUND_EN to round half up in the scaler instead of truncating.
module mavg_antialias
    import mavg_pkg::*;
#(
    parameter int TAPS  = TAPS_DEF,
    parameter int RECIP = RECIP_DEF
)(
    input  logic    CLOCK_50,
    input  logic    reset,
    input  sample_t data_in,
    output sample_t data_out,
    output logic    filt_valid
);

    localparam int ACC_W = DATA_W + $clog2(TAPS);
    localparam int MUL_W = ACC_W + 17;
    localparam int SCL_W = MUL_W - 16;
    localparam int CNT_W = $clog2(TAPS + 1);

    localparam logic signed [MUL_W-1:0] RECIP_EXT = MUL_W'(RECIP);
    localparam logic signed [MUL_W-1:0] HALF_LSB  = MUL_W'(32768);

    sample_t                 oldest;
    logic signed [ACC_W-1:0] sum;
    logic signed [MUL_W-1:0] prod;
    logic signed [MUL_W-1:0] biased;
    logic signed [SCL_W-1:0] scaled;
    sample_t                 sat_val;
    logic [CNT_W-1:0]        fill_cnt;
    logic                    unused_frac;

    mavg_delay_line #(
        .TAPS (TAPS)
    ) u_delay_line (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .data_in  (data_in),
        .oldest   (oldest)
    );

    // Sum is wide enough for TAPS full-scale samples, so it cannot wrap.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else begin
            sum <= sum + ACC_W'(data_in) - ACC_W'(oldest);
        end
    end

    assign prod = MUL_W'(sum) * RECIP_EXT;

`ifdef MAVG_ROUND_EN
    assign biased = prod + HALF_LSB;
`else
    assign biased = prod;
`endif

    assign scaled      = biased[MUL_W-1:16];
    assign unused_frac = ^biased[15:0];

    // RECIP is rounded up, so a full-scale window can land one LSB outside range.
    always_comb begin
        sat_val = scaled[DATA_W-1:0];
        if (scaled > SCL_W'(SAT_MAX)) begin
            sat_val = SAT_MAX;
        end else if (scaled < SCL_W'(SAT_MIN)) begin
            sat_val = SAT_MIN;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            data_out <= sat_val;
        end
    end

    // filt_valid rises on the edge that registers the first full-window sum.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            fill_cnt   <= '0;
            filt_valid <= 1'b0;
        end else begin
            if (fill_cnt != CNT_W'(TAPS)) begin
                fill_cnt <= fill_cnt + CNT_W'(1);
            end
            if (fill_cnt == CNT_W'(TAPS)) begin
                filt_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mavg_antialias.sv
// Scoreboard bench for mavg_antialias: an integer reference model predicts
// each output as samples are driven; outputs are checked on the falling edge.
module tb_mavg_antialias;
    import mavg_pkg::*;

    typedef struct {
        int   edge_no;
        int   data;
        logic valid;
    } exp_t;

    logic    CLOCK_50 = 1'b0;
    logic    reset    = 1'b0;
    sample_t data_in  = '0;
    sample_t data_out;
    logic    filt_valid;

    exp_t sb[$];
    int   win[6];
    int   edge_cnt   = 0;
    int   compared   = 0;
    int   mismatched = 0;

    mavg_antialias dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .data_in    (data_in),
        .data_out   (data_out),
        .filt_valid (filt_valid)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic int scaleModel(input longint s);
        longint p;
        longint q;
        p = s * 10923;
`ifdef MAVG_ROUND_EN
        p = p + 32768;
`endif
        q = p / 65536;
        if (p < 0 && (p % 65536) != 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    task automatic checkValue(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() > 0 && sb[0].edge_no == edge_cnt) begin
            e = sb.pop_front();
            checkValue($sformatf("sb_data_e%0d", edge_cnt), 32'(data_out), 32'(e.data));
            checkValue($sformatf("sb_valid_e%0d", edge_cnt), {31'd0, filt_valid}, {31'd0, e.valid});
        end else begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard_order: observed edge %0d expected queued entry", edge_cnt);
        end
    endtask

    // Drive one sample, predict its full-window output two edges later.
    task automatic applyStimulus(input int x);
        longint s;
        data_in = sample_t'(x);
        for (int i = 5; i > 0; i--) win[i] = win[i-1];
        win[0] = x;
        s = 0;
        for (int i = 0; i < 6; i++) s += longint'(win[i]);
        sb.push_back('{edge_cnt + 2, scaleModel(s), (edge_cnt + 1 >= 6)});
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        edge_cnt++;
        checkOutput();
    endtask

    // Assert reset between edges and check that outputs clear without a clock.
    task automatic doReset(input string tag);
        #5 reset = 1'b1;
        #1;
        checkValue({tag, "_async_data"}, 32'(data_out), 32'sd0);
        checkValue({tag, "_async_valid"}, {31'd0, filt_valid}, 32'sd0);
        @(negedge CLOCK_50);
        checkValue({tag, "_held_data"}, 32'(data_out), 32'sd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) win[i] = 0;
        sb.delete();
        edge_cnt = 0;
        sb.push_back('{1, 0, 1'b0});
    endtask

    initial begin
        @(negedge CLOCK_50);
        doReset("rst0");

        for (int i = 1; i <= 12; i++) begin
            applyStimulus(600);
            if (i == 6) checkValue("c600_warm", 32'(data_out), 32'sd500);
            if (i == 7) begin
                checkValue("c600_full", 32'(data_out), 32'sd600);
                checkValue("c600_valid", {31'd0, filt_valid}, 32'sd1);
            end
        end

        doReset("rst1");
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(i * 100);
            if (i == 7) checkValue("ramp_e7", 32'(data_out), 32'sd350);
            if (i == 8) checkValue("ramp_e8", 32'(data_out), 32'sd450);
            if (i == 9) checkValue("ramp_e9", 32'(data_out), 32'sd550);
        end

        doReset("rst2");
        for (int i = 0; i < 8; i++) applyStimulus(32767);
        checkValue("sat_pos", 32'(data_out), 32'sd32767);

        doReset("rst3");
        for (int i = 0; i < 8; i++) applyStimulus(-32768);
        checkValue("sat_neg", 32'(data_out), -32'sd32768);

        doReset("rst4");
        for (int i = 0; i < 8; i++) applyStimulus(-1);
`ifdef MAVG_ROUND_EN
        checkValue("round_m1", 32'(data_out), -32'sd1);
`else
        checkValue("trunc_m1", 32'(data_out), -32'sd2);
`endif

        for (int i = 0; i < 20; i++) applyStimulus(1000);
        doReset("rst5");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(300);
            if (i == 6) checkValue("re_warm_valid", {31'd0, filt_valid}, 32'sd0);
            if (i == 7) begin
                checkValue("re_full", 32'(data_out), 32'sd300);
                checkValue("re_valid", {31'd0, filt_valid}, 32'sd1);
            end
        end

        for (int i = 0; i < 40; i++) applyStimulus(int'($urandom_range(65535)) - 32768);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
